// File: rtl/sub_12bit_serial_pkg.sv
// Shared arcade datapath definitions: FSM state encodings and operand/counter widths.
package arcade_defs;

    localparam int unsigned ARC_WIDTH = 12;
    localparam int unsigned ARC_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arc_state_t;

endpackage

// File: rtl/sub_12bit_serial_fa.sv
// One-bit full adder cell shared by the arcade datapath.
module fa (
    input  logic A,
    input  logic B,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = A ^ B ^ ci;
    assign co = (A & B) | (ci & (A ^ B));

endmodule

// File: rtl/sub_12bit_serial.sv
// Bit-serial unsigned subtractor: A - B as A + ~B + 1, one fa cell, one bit per clock.
// Optional build macro SUB12_SATURATE_EN clamps diff to zero whenever a borrow occurs.
module sub_12bit_serial
    import arcade_defs::*;
#(
    parameter int unsigned WIDTH = ARC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   calculate_out
);

    localparam int unsigned CNT_W = ARC_CNT_W;

    arc_state_t       r_state;
    arc_state_t       w_state_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH:0]   r_calc;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_diff_next;
    logic [WIDTH-1:0] w_diff_load;

    fa u_fa (
        .A  (r_ra[0]),
        .B  (r_rb[0]),
        .ci (r_c),
        .s  (w_s),
        .co (w_co)
    );

    assign w_accept    = (r_state == IDLE) && start;
    assign w_last      = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_diff_next = {w_s, r_diff[WIDTH-1:1]};

`ifdef SUB12_SATURATE_EN
    assign w_diff_load = w_co ? w_diff_next : '0;
`else
    assign w_diff_load = w_diff_next;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and registered-output targets
    always_comb begin
        w_state_next = r_state;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_busy_next = (w_state_next == RUN) || (w_state_next == DONE);
        w_done_next = (w_state_next == DONE);
    end

    // Serial datapath; the final fa carry-out is the inverted borrow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_calc <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            if (w_accept) begin
                r_ra   <= A;
                r_rb   <= ~B;
                r_c    <= 1'b1;
                r_cnt  <= '0;
                r_diff <= '0;
            end else if (r_state == RUN) begin
                r_ra   <= {1'b0, r_ra[WIDTH-1:1]};
                r_rb   <= {1'b0, r_rb[WIDTH-1:1]};
                r_c    <= w_co;
                r_cnt  <= r_cnt + CNT_W'(1);
                r_diff <= w_diff_next;
            end
            if (w_last) begin
                r_calc <= {~w_co, w_diff_load};
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign calculate_out = r_calc;

endmodule

// File: tb/tb_sub_12bit_serial.sv
// Self-checking bench for sub_12bit_serial against an arithmetic reference model.
module tb_sub_12bit_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] A;
    logic [11:0] B;
    logic        busy;
    logic        done;
    logic [12:0] calculate_out;

    int          total;
    int          bad;
    logic [12:0] exp_calc;

    sub_12bit_serial dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .A             (A),
        .B             (B),
        .busy          (busy),
        .done          (done),
        .calculate_out (calculate_out)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ref_sub(input int a, input int b);
        int  d;
        logic brw;
        brw = (a < b);
        d   = (a - b + 4096) % 4096;
`ifdef SUB12_SATURATE_EN
        if (brw) d = 0;
`endif
        return {brw, 12'(d)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation from the accepting edge N through N+13, checked every cycle
    task automatic run_op(input int a, input int b, input bit mid_pulse);
        logic [12:0] e;
        e     = ref_sub(a, b);
        A     = 12'(a);
        B     = 12'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = 12'($urandom);
        B     = 12'($urandom);
        chk("busy_at_N", {12'd0, busy}, 13'd1);
        chk("done_at_N", {12'd0, done}, 13'd0);
        for (int k = 1; k <= 12; k++) begin
            if (mid_pulse && (k == 3 || k == 12)) start = 1'b1;
            tick();
            start = 1'b0;
            if (k < 12) begin
                chk("busy_run", {12'd0, busy}, 13'd1);
                chk("done_run", {12'd0, done}, 13'd0);
                chk("calc_hold", calculate_out, exp_calc);
            end
        end
        exp_calc = e;
        chk("done_N12", {12'd0, done}, 13'd1);
        chk("busy_N12", {12'd0, busy}, 13'd1);
        chk("result", calculate_out, e);
        tick();
        chk("done_N13", {12'd0, done}, 13'd0);
        chk("busy_N13", {12'd0, busy}, 13'd0);
        chk("result_hold", calculate_out, e);
    endtask

    initial begin
        int a;
        int b;
        logic exp_done;
        logic exp_busy;
        clk      = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        total    = 0;
        bad      = 0;
        exp_calc = '0;

        tick();
        tick();
        chk("rst_busy", {12'd0, busy}, 13'd0);
        chk("rst_done", {12'd0, done}, 13'd0);
        chk("rst_calc", calculate_out, 13'h0000);
        rst = 1'b0;
        tick();

        run_op(100, 37, 1'b0);
        chk("lit_100_37", calculate_out, 13'h003F);

        run_op(5, 9, 1'b0);
`ifdef SUB12_SATURATE_EN
        chk("lit_5_9", calculate_out, 13'h1000);
`else
        chk("lit_5_9", calculate_out, 13'h1FFC);
`endif

        // Back-to-back at the earliest accepting edge
        run_op(0, 0, 1'b0);
        chk("lit_eq", calculate_out, 13'h0000);
        run_op(4095, 0, 1'b0);
        chk("lit_max_0", calculate_out, 13'h0FFF);
        run_op(0, 4095, 1'b0);

        // Starts during RUN/DONE are ignored and not queued
        run_op(1234, 567, 1'b1);
        tick();
        chk("no_queue_busy", {12'd0, busy}, 13'd0);
        chk("no_queue_done", {12'd0, done}, 13'd0);

        // Reset mid-RUN discards the operation
        A     = 12'd300;
        B     = 12'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {12'd0, busy}, 13'd0);
        chk("midrst_done", {12'd0, done}, 13'd0);
        chk("midrst_calc", calculate_out, 13'h0000);
        exp_calc = '0;
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("post_rst_done", {12'd0, done}, 13'd0);
            chk("post_rst_busy", {12'd0, busy}, 13'd0);
        end
        run_op(2048, 1, 1'b0);
        chk("lit_2048_1", calculate_out, 13'h07FF);

        // Held start re-triggers every 14 cycles
        A     = 12'd1;
        B     = 12'd2;
        start = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            tick();
            exp_done = (k == 12) || (k == 26) || (k == 40);
            exp_busy = ((k % 14) <= 12);
            chk("held_done", {12'd0, done}, {12'd0, exp_done});
            chk("held_busy", {12'd0, busy}, {12'd0, exp_busy});
            if (exp_done) begin
                exp_calc = ref_sub(1, 2);
                chk("held_result", calculate_out, exp_calc);
            end
        end
        start = 1'b0;
        tick();
        chk("held_end_busy", {12'd0, busy}, 13'd0);
`ifndef SUB12_SATURATE_EN
        chk("lit_1_2", calculate_out, 13'h1FFF);
`endif

        // Randomized operands
        for (int n = 0; n < 20; n++) begin
            a = int'($urandom_range(0, 4095));
            b = int'($urandom_range(0, 4095));
            run_op(a, b, n[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
